// File: rtl/pipeline_mem_stage_pkg.sv
// pipeline_mem_stage_pkg: shared types for the MEM stage.
// Includes the access FSM states, the size encodings and the EX/MEM bundle.
package pipeline_mem_stage_pkg;
  localparam int XLEN = 32;
  typedef enum logic {IDLE, WAIT} mem_state_t;
  localparam logic [1:0] MEM_SIZE_B = 2'b00;
  localparam logic [1:0] MEM_SIZE_H = 2'b01;
  localparam logic [1:0] MEM_SIZE_W = 2'b10;
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] tgt;
    logic [XLEN-1:0] alu;
    logic            zero;
    logic [XLEN-1:0] rs2;
    logic            branch;
    logic            jump;
    logic            rd;
    logic            wr;
    logic [1:0]      size;
    logic            uns;
  } ex_mem_t;
  function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] a);
    return size == MEM_SIZE_B ? 4'b0001 << a : size == MEM_SIZE_H ? 4'b0011 << {a[1], 1'b0} : 4'b1111;
  endfunction
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    return (size == MEM_SIZE_H & a[0]) | (size == MEM_SIZE_W & |a);
  endfunction
endpackage

// File: rtl/pipeline_mem_stage_if.sv
// pipeline_mem_stage_if: data-memory req/ack bus.
// The stage is the master; the memory is the slave.
interface pipeline_mem_stage_if;
  import pipeline_mem_stage_pkg::*;
  logic            dmem_req;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic [3:0]      dmem_wmask;
  logic            dmem_ack;
  logic [XLEN-1:0] dmem_rdata;
  modport master(output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wmask, input dmem_ack, dmem_rdata);
  modport slave(input dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wmask, output dmem_ack, dmem_rdata);
endinterface

// File: rtl/pipeline_mem_stage_load_align.sv
// pipeline_mem_stage_load_align: selects the load lane from the raw word.
// Then sign- or zero-extends it to XLEN.
module pipeline_mem_stage_load_align
  import pipeline_mem_stage_pkg::*;
(
  input  logic [XLEN-1:0] rdata_i,
  input  logic [1:0]      addr_i,
  input  logic [1:0]      size_i,
  input  logic            uns_i,
  output logic [XLEN-1:0] data_o
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = rdata_i[{addr_i, 3'b000} +: 8];
    h = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    data_o = size_i == MEM_SIZE_B ? {{24{~uns_i & b[7]}}, b} :
             size_i == MEM_SIZE_H ? {{16{~uns_i & h[15]}}, h} : rdata_i;
  end
endmodule

// File: rtl/pipeline_mem_stage.sv
// pipeline_mem_stage: EX/MEM register, branch redirect and dmem load/store over req/ack.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned accesses on misalign_out_MEM.
module pipeline_mem_stage
  import pipeline_mem_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_in_MEM,
  input  logic [XLEN-1:0] PC4_in_MEM,
  input  logic [XLEN-1:0] PC_in_MEM,
  input  logic [XLEN-1:0] ALU_in_MEM,
  input  logic            zero_in_MEM,
  input  logic [XLEN-1:0] Rs2_in_MEM,
  input  logic            Branch_in_MEM,
  input  logic            Jump_in_MEM,
  input  logic            MemRead_in_MEM,
  input  logic            MemWrite_in_MEM,
  input  logic [1:0]      MemSize_in_MEM,
  input  logic            MemUnsigned_in_MEM,
  input  logic            flush_in_MEM,
  pipeline_mem_stage_if.master dmem,
  output logic            stall_out_MEM,
  output logic            PCSrc_out_MEM,
  output logic [XLEN-1:0] PC_target_out_MEM,
  output logic            valid_out_MEM,
  output logic [XLEN-1:0] ALU_out_MEM,
  output logic [XLEN-1:0] Data_out_MEM,
  output logic [XLEN-1:0] PC4_out_MEM
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic            misalign_out_MEM
`endif
);
  ex_mem_t         ex_d, ex_q;
  mem_state_t      state_d, state_q;
  logic            in_mis, q_mis, in_mem, is_load, valid_q;
  logic [XLEN-1:0] alu_q, pc4_q, data_q, data_d, ld_data;
  always_comb begin
    ex_d = '0;
    if (!flush_in_MEM) begin
      ex_d.valid  = valid_in_MEM;
      ex_d.pc4    = PC4_in_MEM;
      ex_d.tgt    = PC_in_MEM;
      ex_d.alu    = ALU_in_MEM;
      ex_d.zero   = zero_in_MEM;
      ex_d.rs2    = Rs2_in_MEM;
      ex_d.branch = Branch_in_MEM;
      ex_d.jump   = Jump_in_MEM;
      ex_d.rd     = MemRead_in_MEM;
      ex_d.wr     = MemWrite_in_MEM;
      ex_d.size   = MemSize_in_MEM;
      ex_d.uns    = MemUnsigned_in_MEM;
    end
  end
`ifdef MEM_MISALIGN_TRAP_EN
  logic mis_q;
  assign in_mis = misaligned(MemSize_in_MEM, ALU_in_MEM[1:0]);
  assign q_mis = ex_q.valid & (ex_q.rd | ex_q.wr) & misaligned(ex_q.size, ex_q.alu[1:0]);
  assign misalign_out_MEM = mis_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) mis_q <= 1'b0;
    else if (!stall_out_MEM) mis_q <= q_mis;
`else
  assign in_mis = 1'b0;
  assign q_mis = 1'b0;
`endif
  // A misaligned trap never opens an access, so it retires straight from IDLE.
  assign in_mem = ex_d.valid & (ex_d.rd | ex_d.wr) & ~in_mis;
  assign stall_out_MEM = (state_q == WAIT) & ~dmem.dmem_ack;
  assign state_d = (stall_out_MEM | in_mem) ? WAIT : IDLE;
  assign is_load = ex_q.rd & ~ex_q.wr & ~q_mis;
  assign data_d = is_load ? ld_data : '0;
  pipeline_mem_stage_load_align u_align (
    .rdata_i(dmem.dmem_rdata),
    .addr_i (ex_q.alu[1:0]),
    .size_i (ex_q.size),
    .uns_i  (ex_q.uns),
    .data_o (ld_data)
  );
  assign dmem.dmem_req   = state_q == WAIT;
  assign dmem.dmem_we    = ex_q.wr;
  assign dmem.dmem_addr  = {ex_q.alu[XLEN-1:2], 2'b00};
  assign dmem.dmem_wdata = ex_q.size == MEM_SIZE_B ? {4{ex_q.rs2[7:0]}} :
                           ex_q.size == MEM_SIZE_H ? {2{ex_q.rs2[15:0]}} : ex_q.rs2;
  assign dmem.dmem_wmask = byte_mask(ex_q.size, ex_q.alu[1:0]);
  assign PCSrc_out_MEM     = ex_q.valid & ((ex_q.branch & ex_q.zero) | ex_q.jump);
  assign PC_target_out_MEM = ex_q.tgt;
  assign valid_out_MEM     = valid_q;
  assign ALU_out_MEM       = alu_q;
  assign Data_out_MEM      = data_q;
  assign PC4_out_MEM       = pc4_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ex_q    <= '0;
      valid_q <= 1'b0;
      alu_q   <= '0;
      pc4_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= ~stall_out_MEM & ex_q.valid;
      if (!stall_out_MEM) begin
        ex_q   <= ex_d;
        alu_q  <= ex_q.alu;
        pc4_q  <= ex_q.pc4;
        data_q <= data_d;
      end
    end
  end
endmodule

// File: tb/tb_pipeline_mem_stage.sv
// tb_pipeline_mem_stage: directed and random instruction streams against a transaction-level model.
// The model tracks the instruction held in MEM, whether its access is open, and the retiring bundle.
module tb_pipeline_mem_stage;
  typedef struct packed {
    logic v; logic [31:0] pc4, tgt, alu; logic z; logic [31:0] rs2;
    logic br, jmp, rd, wr; logic [1:0] sz; logic u;
  } ins_t;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  ins_t in_i = '0;
  logic flush = 1'b0;
  pipeline_mem_stage_if dmem();
  logic stall, pcsrc, vout;
  logic [31:0] tgt, alu_o, data_o, pc4_o;
`ifdef MEM_MISALIGN_TRAP_EN
  logic mis_o;
`endif
  pipeline_mem_stage dut (
    .clk(clk), .rst_n(rst_n), .valid_in_MEM(in_i.v), .PC4_in_MEM(in_i.pc4), .PC_in_MEM(in_i.tgt),
    .ALU_in_MEM(in_i.alu), .zero_in_MEM(in_i.z), .Rs2_in_MEM(in_i.rs2), .Branch_in_MEM(in_i.br),
    .Jump_in_MEM(in_i.jmp), .MemRead_in_MEM(in_i.rd), .MemWrite_in_MEM(in_i.wr), .MemSize_in_MEM(in_i.sz),
    .MemUnsigned_in_MEM(in_i.u), .flush_in_MEM(flush), .dmem(dmem), .stall_out_MEM(stall),
    .PCSrc_out_MEM(pcsrc), .PC_target_out_MEM(tgt), .valid_out_MEM(vout), .ALU_out_MEM(alu_o),
    .Data_out_MEM(data_o), .PC4_out_MEM(pc4_o)
`ifdef MEM_MISALIGN_TRAP_EN
    , .misalign_out_MEM(mis_o)
`endif
  );
  int checks = 0, fails = 0;
  ins_t cur = '0;
  logic open = 1'b0, ov = 1'b0, oload = 1'b0, ack_v;
  int lat = 0, wcnt = 0, fix_lat = -1;
  logic use_rd = 1'b0;
  logic [31:0] fix_rd = '0, rdata_v = '0, oalu = '0, opc4 = '0, odata = '0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [31:0] exp_load(input logic [31:0] w, input logic [31:0] a, input logic [1:0] sz, input logic u);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (w >> (8 * (a % 4))) & 32'hFF;
      if (!u && v >= 128) v = v + 32'hFFFFFF00;
    end else if (sz == 2'd1) begin
      v = (w >> (8 * (a & 2))) & 32'hFFFF;
      if (!u && v >= 32768) v = v + 32'hFFFF0000;
    end else v = w;
    return v;
  endfunction
  function automatic logic [31:0] exp_mask(input logic [1:0] sz, input logic [31:0] a);
    return sz == 2'd0 ? 32'(1 << (a % 4)) : sz == 2'd1 ? 32'(3 << (a & 2)) : 32'd15;
  endfunction
  function automatic logic [31:0] exp_wdata(input logic [1:0] sz, input logic [31:0] d);
    return sz == 2'd0 ? 32'(d[7:0]) * 32'h01010101 : sz == 2'd1 ? 32'(d[15:0]) * 32'h00010001 : d;
  endfunction
  function automatic ins_t mem_op(input logic rd, input logic wr, input logic [1:0] sz, input logic u,
                                  input logic [31:0] a, input logic [31:0] d);
    ins_t i = '0;
    i.v = 1'b1; i.rd = rd; i.wr = wr; i.sz = sz; i.u = u; i.alu = a; i.rs2 = d; i.pc4 = a + 32'h10;
    return i;
  endfunction
  function automatic ins_t alu_op(input logic [31:0] a);
    ins_t i = '0;
    i.v = 1'b1; i.alu = a; i.pc4 = 32'h0000_0204;
    return i;
  endfunction
  function automatic ins_t rnd();
    ins_t i = '0;
    int k = $urandom_range(0, 99);
    i.v = k < 90; i.pc4 = $urandom; i.tgt = $urandom; i.alu = $urandom; i.rs2 = $urandom; i.z = 1'($urandom);
    k = $urandom_range(0, 9);
    if (k < 3) begin
      i.br = 1'($urandom); i.jmp = !i.br;
    end else if (k < 8) begin
      i.rd = 1'($urandom); i.wr = !i.rd || k == 7; i.sz = 2'($urandom_range(0, 2)); i.u = 1'($urandom);
      if (k == 6) i.alu = 32'hFFFF_FFFC;
    end
    return i;
  endfunction
  task automatic cyc(input ins_t i, input logic fl);
    logic st;
    in_i = i; flush = fl;
    ack_v = open && wcnt == lat;
    dmem.dmem_ack = ack_v;
    dmem.dmem_rdata = ack_v ? rdata_v : $urandom;
    st = open && !ack_v;
    #1;
    chk("req", 32'(dmem.dmem_req), 32'(open));
    chk("stall", 32'(stall), 32'(st));
    chk("pcsrc", 32'(pcsrc), 32'(cur.v && ((cur.br && cur.z) || cur.jmp)));
    if (cur.v) chk("pc_target", tgt, cur.tgt);
    if (open) begin
      chk("we", 32'(dmem.dmem_we), 32'(cur.wr));
      chk("addr", dmem.dmem_addr, cur.alu & 32'hFFFF_FFFC);
      if (cur.wr) chk("wmask", 32'(dmem.dmem_wmask), exp_mask(cur.sz, cur.alu));
      if (cur.wr) chk("wdata", dmem.dmem_wdata, exp_wdata(cur.sz, cur.rs2));
    end
    chk("valid_out", 32'(vout), 32'(ov));
    if (ov) begin
      chk("alu_out", alu_o, oalu);
      chk("pc4_out", pc4_o, opc4);
      if (oload) chk("data_out", data_o, odata);
    end
    @(posedge clk);
    if (st) begin
      ov = 1'b0; wcnt++;
    end else begin
      ov = cur.v; oalu = cur.alu; opc4 = cur.pc4;
      oload = cur.v && cur.rd && !cur.wr;
      odata = exp_load(rdata_v, cur.alu, cur.sz, cur.u);
      cur = fl ? '0 : i;
      open = cur.v && (cur.rd || cur.wr);
      wcnt = 0;
      lat = fix_lat >= 0 ? fix_lat : $urandom_range(0, 3);
      rdata_v = use_rd ? fix_rd : $urandom;
    end
    @(negedge clk);
  endtask
  task automatic do_reset();
    rst_n = 1'b0; dmem.dmem_ack = 1'b0;
    #1;
    chk("rst_req", 32'(dmem.dmem_req), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_valid", 32'(vout), 32'd0);
    chk("rst_pcsrc", 32'(pcsrc), 32'd0);
    chk("rst_outs", alu_o | data_o | pc4_o | tgt, 32'd0);
    cur = '0; open = 1'b0; ov = 1'b0; wcnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    ins_t b;
    dmem.dmem_ack = 1'b0; dmem.dmem_rdata = '0;
    @(negedge clk);
    do_reset();
    cyc(alu_op(32'h1234), 1'b0);
    cyc('0, 1'b0);
    cyc('0, 1'b0);
    fix_lat = 2;
    cyc(mem_op(1'b0, 1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF), 1'b0);
    for (int k = 0; k < 4; k++) cyc('0, 1'b0);
    fix_lat = 0; use_rd = 1'b1; fix_rd = 32'h80A5_5A11;
    cyc(mem_op(1'b1, 1'b0, 2'd0, 1'b0, 32'h103, 0), 1'b0);
    cyc(mem_op(1'b1, 1'b0, 2'd0, 1'b1, 32'h103, 0), 1'b0);
    for (int k = 0; k < 3; k++) cyc('0, 1'b0);
    use_rd = 1'b0;
    b = '0; b.v = 1'b1; b.br = 1'b1; b.z = 1'b1; b.tgt = 32'h40;
    cyc(b, 1'b0);
    b.z = 1'b0;
    cyc(b, 1'b0);
    cyc('0, 1'b0);
    fix_lat = 3;
    cyc(mem_op(1'b0, 1'b1, 2'd1, 1'b0, 32'h202, 32'h1234_5678), 1'b0);
    cyc('0, 1'b0);
    do_reset();
    fix_lat = -1;
    cyc(alu_op(32'h55), 1'b0);
    cyc('0, 1'b0);
    cyc('0, 1'b0);
    fix_lat = 2;
    cyc(mem_op(1'b1, 1'b0, 2'd2, 1'b0, 32'hFFFF_FFFC, 0), 1'b0);
    cyc(alu_op(32'h77), 1'b1);
    cyc(alu_op(32'h77), 1'b1);
    cyc(alu_op(32'h88), 1'b1);
    cyc(alu_op(32'h99), 1'b0);
    fix_lat = 0;
    cyc(mem_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h300, 0), 1'b0);
    cyc(mem_op(1'b1, 1'b0, 2'd1, 1'b0, 32'h306, 0), 1'b0);
    cyc(mem_op(1'b1, 1'b0, 2'd1, 1'b1, 32'h30A, 0), 1'b0);
    cyc('0, 1'b0);
    cyc('0, 1'b0);
    fix_lat = -1;
    for (int k = 0; k < 600; k++) cyc(rnd(), $urandom_range(0, 19) == 0);
    for (int k = 0; k < 6; k++) cyc('0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
